// File: rtl/byte_div_seq_pkg.sv
// Shared types and constants for the sequential byte divider.
package byte_div_seq_pkg;

   localparam int WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] DIV0_Q = 8'hFF;

endpackage

// File: rtl/byte_div_seq_sub.sv
// Byte subtractor with borrow: {o, O} = a - b - c. Combinational, no flow control.
module byte_div_seq_sub
   import byte_div_seq_pkg::*;
(
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c,
   output logic [WIDTH-1:0] O,
   output logic             o
);

   logic [WIDTH:0] diff_ext;

   assign diff_ext = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, c};
   assign O        = diff_ext[WIDTH-1:0];
   assign o        = diff_ext[WIDTH];

endmodule

// File: rtl/byte_div_seq.sv
// Restoring divider, one trial subtraction per clock; done pulses 9 cycles after start (1 for /0).
// start is only accepted in IDLE; requests while busy are dropped, not queued.
module byte_div_seq #(
   parameter int WIDTH = byte_div_seq_pkg::WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] r,
   output logic             div0
);
   import byte_div_seq_pkg::*;

   localparam int             CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] q_sh;
   logic [WIDTH-1:0] d_reg;
   logic [WIDTH-1:0] p_reg;
   logic [CNT_W-1:0] cnt;

   logic [WIDTH:0]   trial;
   logic [WIDTH-1:0] diff;
   logic             borrow;
   logic             accept;
   logic [WIDTH-1:0] p_next;
   logic [WIDTH-1:0] q_next;

   assign trial = {p_reg, q_sh[WIDTH-1]};

   byte_div_seq_sub byte_sub (
      .a (trial[WIDTH-1:0]),
      .b (d_reg),
      .c (1'b0),
      .O (diff),
      .o (borrow)
   );

   // The 9th trial bit means T >= 256 > D, so the subtraction must be accepted
   // even though the 8-bit subtractor reports a borrow.
   assign accept = trial[WIDTH] | ~borrow;
   assign p_next = accept ? diff : trial[WIDTH-1:0];
   assign q_next = {q_sh[WIDTH-2:0], accept};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         q     <= '0;
         r     <= '0;
         div0  <= 1'b0;
         q_sh  <= '0;
         d_reg <= '0;
         p_reg <= '0;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  q_sh  <= dividend;
                  d_reg <= divisor;
                  p_reg <= '0;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  if (divisor == '0) begin
                     state <= DONE;
                     done  <= 1'b1;
                     q     <= DIV0_Q;
                     r     <= dividend;
                     div0  <= 1'b1;
                  end else begin
                     state <= RUN;
                     div0  <= 1'b0;
                  end
               end
            end
            RUN: begin
               p_reg <= p_next;
               q_sh  <= q_next;
               cnt   <= cnt + 1'b1;
               if (cnt == LAST_STEP) begin
                  state <= DONE;
                  done  <= 1'b1;
                  q     <= q_next;
                  r     <= p_next;
               end
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_byte_div_seq.sv
// Directed and randomized checks of byte_div_seq against an arithmetic reference.
module tb_byte_div_seq;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [7:0] dividend;
   logic [7:0] divisor;
   logic       busy;
   logic       done;
   logic [7:0] q;
   logic [7:0] r;
   logic       div0;

   int checks = 0;
   int errors = 0;

   byte_div_seq #(.WIDTH(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .dividend (dividend),
      .divisor  (divisor),
      .busy     (busy),
      .done     (done),
      .q        (q),
      .r        (r),
      .div0     (div0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Issues one operation and returns the number of edges after the
   // accepting edge at which done was first seen (-1 on timeout).
   task automatic do_op(input logic [7:0] a, input logic [7:0] b, output int lat);
      @(negedge clk);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      lat = -1;
      for (int n = 0; n < 30; n++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            lat = n;
            break;
         end
      end
   endtask

   // Reference: plain integer division, with the divide-by-zero convention.
   task automatic op_and_check(input string tag, input logic [7:0] a, input logic [7:0] b,
                               input bit check_lat);
      int lat;
      int exp_q, exp_r;
      do_op(a, b, lat);
      if (b == 0) begin
         exp_q = 255;
         exp_r = a;
      end else begin
         exp_q = a / b;
         exp_r = a % b;
      end
      if (check_lat) begin
         if (b == 0) chk({tag, " lat"}, 32'(lat >= 0 && lat <= 1), 32'd1);
         else        chk({tag, " lat"}, 32'(lat), 32'd8);
      end else begin
         chk({tag, " done_seen"}, 32'(lat >= 0), 32'd1);
      end
      chk({tag, " q"}, {24'd0, q}, 32'(exp_q));
      chk({tag, " r"}, {24'd0, r}, 32'(exp_r));
      if (check_lat) chk({tag, " div0"}, {31'd0, div0}, {31'd0, (b == 0)});
   endtask

   initial begin
      int lat;
      int busy_cnt;
      int done_cnt;
      logic [7:0] ra, rb;

      rst_n    = 1'b0;
      start    = 1'b0;
      dividend = 8'd0;
      divisor  = 8'd0;
      #12;
      chk("reset busy", {31'd0, busy}, 32'd0);
      chk("reset done", {31'd0, done}, 32'd0);
      chk("reset q",    {24'd0, q},    32'd0);
      chk("reset r",    {24'd0, r},    32'd0);
      chk("reset div0", {31'd0, div0}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      op_and_check("200/7",     8'd200, 8'd7,   1'b1);
      @(negedge clk);
      chk("done one cycle", {31'd0, done}, 32'd0);
      chk("busy after done", {31'd0, busy}, 32'd0);
      chk("q holds", {24'd0, q}, 32'd28);
      op_and_check("255/1",     8'd255, 8'd1,   1'b1);
      op_and_check("5/9",       8'd5,   8'd9,   1'b1);
      op_and_check("FF/80",     8'hFF,  8'h80,  1'b1);
      op_and_check("77/0",      8'd77,  8'd0,   1'b1);
      @(negedge clk);
      chk("div0 holds", {31'd0, div0}, 32'd1);
      op_and_check("10/3",      8'd10,  8'd3,   1'b1);

      // A second start while running must be ignored.
      @(negedge clk);
      dividend = 8'd100;
      divisor  = 8'd10;
      start    = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      busy_cnt = 0;
      done_cnt = 0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (busy === 1'b1) busy_cnt++;
         if (done === 1'b1) done_cnt++;
         if (n == 3) begin
            dividend = 8'd9;
            divisor  = 8'd2;
            start    = 1'b1;
         end else begin
            start = 1'b0;
         end
      end
      chk("ignored start busy cycles", 32'(busy_cnt), 32'd9);
      chk("ignored start done count", 32'(done_cnt), 32'd1);
      chk("ignored start q", {24'd0, q}, 32'd10);
      chk("ignored start r", {24'd0, r}, 32'd0);

      // Reset in the middle of an operation aborts it.
      @(negedge clk);
      dividend = 8'd200;
      divisor  = 8'd7;
      start    = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort busy", {31'd0, busy}, 32'd0);
      chk("abort done", {31'd0, done}, 32'd0);
      chk("abort q",    {24'd0, q},    32'd0);
      chk("abort r",    {24'd0, r},    32'd0);
      chk("abort div0", {31'd0, div0}, 32'd0);
      done_cnt = 0;
      for (int n = 0; n < 12; n++) begin
         @(negedge clk);
         if (done === 1'b1) done_cnt++;
         if (n == 2) rst_n = 1'b1;
      end
      chk("abort no done", 32'(done_cnt), 32'd0);
      op_and_check("50/5", 8'd50, 8'd5, 1'b1);

      for (int i = 0; i < 2000; i++) begin
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(1, 255));
         op_and_check("random", ra, rb, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
